// File: rtl/demux_1xn_seq_pkg.sv
// Shared definitions for the 1-to-N registered demultiplexer.
// Default geometry, the select-mode encoding and the pointer wrap helper.
package demux_1xn_seq_pkg;

   localparam int DEF_N = 4;
   localparam int DEF_W = 4;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } mode_e;

   function automatic int unsigned wrap_inc(
      input int unsigned v,
      input int unsigned n
   );
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/demux_1xn_seq_if.sv
// Producer/consumer bundle of the 1-to-N demultiplexer.
// The master drives the word and the lane acks; the slave is the demux.
interface demux_1xn_seq_if
   import demux_1xn_seq_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int W  = DEF_W,
   parameter int SW = $clog2(N)
);

   logic          En;
   logic          mode;
   logic [W-1:0]  d;
   logic [SW-1:0] sel;
   logic          in_valid;
   logic          in_ready;
   logic [SW-1:0] cur_lane;
   logic [N*W-1:0] o;
   logic [N-1:0]  o_valid;
   logic [N-1:0]  o_ack;
   logic [7:0]    xfer_cnt;

   modport master (
      output En, mode, d, sel, in_valid, o_ack,
      input  in_ready, cur_lane, o, o_valid, xfer_cnt
   );

   modport slave (
      input  En, mode, d, sel, in_valid, o_ack,
      output in_ready, cur_lane, o, o_valid, xfer_cnt
   );

endinterface

// File: rtl/demux_1xn_seq_lane.sv
// One-entry lane holding register with valid/ack handshake.
// A write in the same cycle as an ack reloads the lane without a bubble.
module demux_lane #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr,
   input  logic [W-1:0] wdata,
   input  logic         ack,
   output logic [W-1:0] q,
   output logic         valid
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q     <= '0;
         valid <= 1'b0;
      end else if (wr) begin
         q     <= wdata;
         valid <= 1'b1;
      end else if (ack) begin
         // data is kept on drain, only the valid flag drops
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_1xn_seq.sv
// Registered 1-to-N demultiplexer with explicit or round-robin lane choice.
// Back-pressure on a lane stalls only writes aimed at that lane.
module demux_1xn_seq
   import demux_1xn_seq_pkg::*;
#(
   parameter  int N  = DEF_N,
   parameter  int W  = DEF_W,
   localparam int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           En,
   input  logic           mode,
   input  logic [W-1:0]   d,
   input  logic [SW-1:0]  sel,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [SW-1:0]  cur_lane,
   output logic [N*W-1:0] o,
   output logic [N-1:0]   o_valid,
   input  logic [N-1:0]   o_ack,
   output logic [7:0]     xfer_cnt
);

   logic [SW-1:0] rr_ptr;
   logic [SW-1:0] tgt;
   logic [N-1:0]  hit;
   logic [N-1:0]  wr;
   logic          accept;
   logic          rr_mode;

   assign rr_mode  = (mode == MODE_RR);
   assign tgt      = rr_mode ? rr_ptr : sel;
   assign cur_lane = tgt;

   // an out-of-range select decodes to no lane at all
   always_comb begin
      hit = '0;
      for (int k = 0; k < N; k++)
         hit[k] = (tgt == SW'(k));
   end

   assign in_ready = En & rst_n & (|(hit & (~o_valid | o_ack)));
   assign accept   = in_valid & in_ready;
   assign wr       = hit & {N{accept}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rr_ptr <= '0;
      else if (accept && rr_mode)
         rr_ptr <= SW'(wrap_inc(32'(rr_ptr), N));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         xfer_cnt <= '0;
      else if (accept)
         xfer_cnt <= xfer_cnt + 8'd1;
   end

   for (genvar k = 0; k < N; k++) begin : g_lane
      demux_lane #(.W(W)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .wr    (wr[k]),
         .wdata (d),
         .ack   (o_ack[k]),
         .q     (o[k*W +: W]),
         .valid (o_valid[k])
      );
   end

endmodule

// File: tb/tb_demux_1xn_seq.sv
// Directed bench for demux_1xn_seq: vector table plus reset and
// counter-wrap sequences.
module tb_demux_1xn_seq;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int SW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   demux_1xn_seq_if #(.N(N), .W(W)) bus ();

   demux_1xn_seq #(.N(N), .W(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .En       (bus.En),
      .mode     (bus.mode),
      .d        (bus.d),
      .sel      (bus.sel),
      .in_valid (bus.in_valid),
      .in_ready (bus.in_ready),
      .cur_lane (bus.cur_lane),
      .o        (bus.o),
      .o_valid  (bus.o_valid),
      .o_ack    (bus.o_ack),
      .xfer_cnt (bus.xfer_cnt)
   );

   typedef struct {
      logic           rst;
      logic           en;
      logic           mode;
      logic [SW-1:0]  sel;
      logic [W-1:0]   d;
      logic           iv;
      logic [N-1:0]   ack;
      logic           rdy;
      logic [SW-1:0]  cur;
      logic [N*W-1:0] o;
      logic [N-1:0]   ov;
      logic [7:0]     cnt;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic vec_t mk(
      input logic rst, input logic en, input logic mode,
      input logic [SW-1:0] sel, input logic [W-1:0] d,
      input logic iv, input logic [N-1:0] ack,
      input logic rdy, input logic [SW-1:0] cur,
      input logic [N*W-1:0] o, input logic [N-1:0] ov,
      input logic [7:0] cnt
   );
      vec_t v;
      v.rst = rst; v.en = en; v.mode = mode; v.sel = sel;
      v.d = d; v.iv = iv; v.ack = ack; v.rdy = rdy;
      v.cur = cur; v.o = o; v.ov = ov; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      rst_n        = v.rst;
      bus.En       = v.en;
      bus.mode     = v.mode;
      bus.sel      = v.sel;
      bus.d        = v.d;
      bus.in_valid = v.iv;
      bus.o_ack    = v.ack;
      #1;
      chk($sformatf("v%0d.in_ready", idx), 32'(bus.in_ready), 32'(v.rdy));
      chk($sformatf("v%0d.cur_lane", idx), 32'(bus.cur_lane), 32'(v.cur));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.o", idx), 32'(bus.o), 32'(v.o));
      chk($sformatf("v%0d.o_valid", idx), 32'(bus.o_valid), 32'(v.ov));
      chk($sformatf("v%0d.xfer_cnt", idx), 32'(bus.xfer_cnt), 32'(v.cnt));
      n_vec++;
   endtask

   initial begin
      bus.En = 1'b1; bus.mode = 1'b0; bus.sel = '0; bus.d = '0;
      bus.in_valid = 1'b1; bus.o_ack = '0;

      //               rst en md sel d   iv ack      rdy cur o         ov       cnt
      tbl.push_back(mk(0, 1, 0, 0, 4'h9, 1, 4'b0000, 0, 0, 16'h0000, 4'b0000, 0));
      tbl.push_back(mk(0, 1, 0, 0, 4'h9, 1, 4'b0000, 0, 0, 16'h0000, 4'b0000, 0));
      tbl.push_back(mk(1, 1, 0, 0, 4'h9, 1, 4'b0000, 1, 0, 16'h0009, 4'b0001, 1));
      tbl.push_back(mk(1, 1, 0, 1, 4'h9, 1, 4'b0000, 1, 1, 16'h0099, 4'b0011, 2));
      tbl.push_back(mk(1, 1, 0, 2, 4'h9, 1, 4'b0000, 1, 2, 16'h0999, 4'b0111, 3));
      tbl.push_back(mk(1, 1, 0, 3, 4'h9, 1, 4'b0000, 1, 3, 16'h9999, 4'b1111, 4));
      tbl.push_back(mk(1, 1, 0, 2, 4'h9, 1, 4'b0000, 0, 2, 16'h9999, 4'b1111, 4));
      tbl.push_back(mk(1, 1, 1, 0, 4'h1, 1, 4'b1111, 1, 0, 16'h9991, 4'b0001, 5));
      tbl.push_back(mk(1, 1, 1, 0, 4'h2, 1, 4'b1111, 1, 1, 16'h9921, 4'b0010, 6));
      tbl.push_back(mk(1, 1, 1, 0, 4'h3, 1, 4'b1111, 1, 2, 16'h9321, 4'b0100, 7));
      tbl.push_back(mk(1, 1, 1, 0, 4'h4, 1, 4'b1111, 1, 3, 16'h4321, 4'b1000, 8));
      tbl.push_back(mk(1, 1, 1, 0, 4'h5, 1, 4'b1111, 1, 0, 16'h4325, 4'b0001, 9));
      tbl.push_back(mk(1, 1, 0, 1, 4'h6, 1, 4'b0000, 1, 1, 16'h4365, 4'b0011, 10));
      tbl.push_back(mk(1, 1, 0, 1, 4'h7, 1, 4'b0010, 1, 1, 16'h4375, 4'b0011, 11));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(1, 0, 1, 0, 4'h8, 1, 4'b0000, 0, 1, 16'h4375, 4'b0011, 11));
      tbl.push_back(mk(1, 0, 1, 0, 4'h8, 1, 4'b1111, 0, 1, 16'h4375, 4'b0000, 11));
      tbl.push_back(mk(1, 1, 1, 0, 4'h8, 1, 4'b0000, 1, 1, 16'h4385, 4'b0010, 12));
      tbl.push_back(mk(1, 1, 0, 3, 4'hA, 1, 4'b0011, 1, 3, 16'hA385, 4'b1000, 13));
      tbl.push_back(mk(1, 1, 1, 0, 4'hB, 1, 4'b0000, 1, 2, 16'hAB85, 4'b1100, 14));
      tbl.push_back(mk(1, 1, 1, 0, 4'hC, 1, 4'b0000, 0, 3, 16'hAB85, 4'b1100, 14));
      tbl.push_back(mk(1, 1, 1, 0, 4'hC, 1, 4'b1000, 1, 3, 16'hCB85, 4'b1100, 15));
      tbl.push_back(mk(1, 1, 0, 0, 4'hF, 0, 4'b0000, 1, 0, 16'hCB85, 4'b1100, 15));

      foreach (tbl[i]) apply(tbl[i], i);

      // reset in the middle of a cycle clears everything without an edge
      @(posedge clk);
      #2;
      bus.in_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst.o", 32'(bus.o), 32'h0);
      chk("mid_rst.o_valid", 32'(bus.o_valid), 32'h0);
      chk("mid_rst.in_ready", 32'(bus.in_ready), 32'h0);
      chk("mid_rst.xfer_cnt", 32'(bus.xfer_cnt), 32'h0);
      n_vec++;

      // 256 round-robin accepts with every lane acked each cycle
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         rst_n = 1'b1;
         bus.En = 1'b1;
         bus.mode = 1'b1;
         bus.in_valid = 1'b1;
         bus.o_ack = '1;
         bus.d = W'(i);
         #1;
         chk($sformatf("wrap%0d.cur_lane", i), 32'(bus.cur_lane), 32'(i % N));
         chk($sformatf("wrap%0d.in_ready", i), 32'(bus.in_ready), 32'h1);
         @(posedge clk);
         #1;
         if (i == 254)
            chk("wrap.cnt255", 32'(bus.xfer_cnt), 32'd255);
         n_vec++;
      end
      chk("wrap.cnt0", 32'(bus.xfer_cnt), 32'd0);
      chk("wrap.o_valid", 32'(bus.o_valid), 32'b1000);
      chk("wrap.lane3", 32'(bus.o[15:12]), 32'hF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
